// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/add/sub, optional iterative shift-add MUL.
// Define ALU_MULTICYCLE_MUL_EN to build the multiplier and its BUSY state.
module alu_multicycle #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       f,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             carry,
    output logic             ovf,
    output logic             neg,
    output logic             err
);

    typedef struct packed {
        logic [WIDTH-1:0] y;
        logic             zero;
        logic             carry;
        logic             ovf;
        logic             neg;
        logic             err;
    } res_t;

`ifdef ALU_MULTICYCLE_MUL_EN
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`endif

    state_t           state;
    res_t             res;
    res_t             alu_c;
    logic [WIDTH:0]   add_c;
    logic [WIDTH:0]   sub_c;

    // Single-cycle result for the non-multiply opcodes; illegal opcodes fall to default.
    always_comb begin
        add_c = {1'b0, a} + {1'b0, b};
        sub_c = {1'b0, a} - {1'b0, b};
        alu_c = '0;
        case (f)
            3'd0: alu_c.y = a & b;
            3'd1: alu_c.y = a | b;
            3'd2: alu_c.y = ~(a & b);
            3'd3: alu_c.y = ~(a | b);
            3'd4: begin
                alu_c.y     = add_c[WIDTH-1:0];
                alu_c.carry = add_c[WIDTH];
                alu_c.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (add_c[WIDTH-1] != a[WIDTH-1]);
            end
            3'd5: begin
                alu_c.y     = sub_c[WIDTH-1:0];
                alu_c.carry = sub_c[WIDTH];
                alu_c.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (sub_c[WIDTH-1] != a[WIDTH-1]);
            end
            default: alu_c.err = 1'b1;
        endcase
        alu_c.zero = (alu_c.y == '0);
        alu_c.neg  = alu_c.y[WIDTH-1];
    end

`ifdef ALU_MULTICYCLE_MUL_EN
    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   mcand;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     psum_c;
    logic [2*WIDTH-1:0] pnext_c;
    res_t               mul_c;

    // One shift-add step: conditionally add multiplicand to the high half, shift right.
    always_comb begin
        psum_c  = {1'b0, prod[2*WIDTH-1:WIDTH]}
                + (prod[0] ? {1'b0, mcand} : {(WIDTH+1){1'b0}});
        pnext_c = {psum_c, prod[WIDTH-1:1]};
        mul_c       = '0;
        mul_c.y     = pnext_c[WIDTH-1:0];
        mul_c.carry = |pnext_c[2*WIDTH-1:WIDTH];
        mul_c.zero  = (mul_c.y == '0);
        mul_c.neg   = mul_c.y[WIDTH-1];
    end
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            res       <= '0;
`ifdef ALU_MULTICYCLE_MUL_EN
            prod      <= '0;
            mcand     <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
`ifdef ALU_MULTICYCLE_MUL_EN
                        if (f == 3'd6) begin
                            state    <= BUSY;
                            in_ready <= 1'b0;
                            prod     <= {{WIDTH{1'b0}}, a};
                            mcand    <= b;
                            cnt      <= '0;
                        end else begin
`else
                        begin
`endif
                            state     <= DONE;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            res       <= alu_c;
                        end
                    end
                end
`ifdef ALU_MULTICYCLE_MUL_EN
                BUSY: begin
                    prod <= pnext_c;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        res       <= mul_c;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        in_ready  <= 1'b1;
                        out_valid <= 1'b0;
                        res       <= '0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    res       <= '0;
                end
            endcase
        end
    end

    assign y     = res.y;
    assign zero  = res.zero;
    assign carry = res.carry;
    assign ovf   = res.ovf;
    assign neg   = res.neg;
    assign err   = res.err;

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (WIDTH=32); honours ALU_MULTICYCLE_MUL_EN.
module tb_alu_multicycle;

    localparam int unsigned W = 32;
`ifdef ALU_MULTICYCLE_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic [2:0]   f_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         zero, carry, ovf, neg, err;

    int total = 0;
    int bad   = 0;

    alu_multicycle #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a_i), .b(b_i), .f(f_i), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .zero(zero), .carry(carry), .ovf(ovf), .neg(neg), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference: {y, zero, carry, ovf, neg, err} from plain integer arithmetic.
    function automatic logic [W+4:0] model_op(input logic [W-1:0] x, input logic [W-1:0] z,
                                              input logic [2:0] op);
        longint unsigned ux = 64'(x);
        longint unsigned uz = 64'(z);
        longint          sx = longint'($signed(x));
        longint          sz = longint'($signed(z));
        longint unsigned r  = 0;
        longint          s  = 0;
        logic            c  = 1'b0;
        logic            v  = 1'b0;
        logic            e  = 1'b0;
        logic [W-1:0]    yr;
        case (op)
            3'd0: r = ux & uz;
            3'd1: r = ux | uz;
            3'd2: r = ~(ux & uz);
            3'd3: r = ~(ux | uz);
            3'd4: begin
                r = ux + uz;
                c = (r > 64'h0000_0000_FFFF_FFFF);
                s = sx + sz;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd5: begin
                r = ux - uz;
                c = (ux < uz);
                s = sx - sz;
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            3'd6: begin
                if (MUL_EN) begin
                    r = ux * uz;
                    c = ((r >> 32) != 0);
                end else begin
                    e = 1'b1;
                end
            end
            default: e = 1'b1;
        endcase
        yr = r[W-1:0];
        return {yr, (yr == 0), c, v, yr[W-1], e};
    endfunction

    function automatic int model_lat(input logic [2:0] op);
        return (MUL_EN && op == 3'd6) ? W + 1 : 1;
    endfunction

    // Transaction-level model: pending result, countdown to valid, handshake release.
    logic         m_busy = 1'b0, m_valid = 1'b0, chk_en = 1'b0;
    int           m_wait = 0;
    logic [W+4:0] m_res  = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_valid <= 1'b0;
            chk_en  <= 1'b1;
        end else if (m_valid) begin
            if (out_ready) m_valid <= 1'b0;
        end else if (m_busy) begin
            if (m_wait == 1) begin
                m_busy  <= 1'b0;
                m_valid <= 1'b1;
            end
            m_wait <= m_wait - 1;
        end else if (in_valid) begin
            m_res <= model_op(a_i, b_i, f_i);
            if (model_lat(f_i) == 1) m_valid <= 1'b1;
            else begin
                m_busy <= 1'b1;
                m_wait <= model_lat(f_i) - 1;
            end
        end
    end

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_in_ready", 64'(in_ready), 64'(!(m_busy || m_valid)));
            chk("cyc_out_valid", 64'(out_valid), 64'(m_valid));
            chk("cyc_y", 64'(y), m_valid ? 64'(m_res[W+4:5]) : 64'd0);
            chk("cyc_flags", 64'({zero, carry, ovf, neg, err}), m_valid ? 64'(m_res[4:0]) : 64'd0);
        end
    end

    task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] z, input logic [2:0] op,
                         input int hold, input bit poke, output int lat,
                         output logic [W-1:0] ry, output logic [4:0] rf, output bit rdy_seen);
        @(negedge clk);
        a_i = x; b_i = z; f_i = op; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0; a_i = ~x; b_i = z ^ 32'h5A5A_5A5A; f_i = 3'd4;
        lat = 1;
        rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            rdy_seen = rdy_seen | in_ready;
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL timeout: out_valid got 0 want 1 within 200 cycles");
        end
        ry = y;
        rf = {zero, carry, ovf, neg, err};
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                in_valid = 1'b1; a_i = 32'd7; b_i = 32'd9; f_i = 3'd4;
            end
            @(negedge clk);
            chk("hold_y", 64'(y), 64'(ry));
            chk("hold_flags", 64'({zero, carry, ovf, neg, err}), 64'(rf));
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    typedef struct { logic [W-1:0] x; logic [W-1:0] z; logic [2:0] op; int hold; } vec_t;
    vec_t vecs[12] = '{
        '{32'hF0F0_1234, 32'h0FF0_FFFF, 3'd0, 0}, '{32'hF0F0_1234, 32'h0FF0_0000, 3'd1, 1},
        '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd2, 0}, '{32'h8000_0000, 32'h0000_0001, 3'd3, 2},
        '{32'h7FFF_FFFF, 32'h0000_0001, 3'd4, 0}, '{32'h8000_0000, 32'h8000_0000, 3'd4, 1},
        '{32'h0000_0005, 32'h0000_0005, 3'd5, 0}, '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'd5, 3},
        '{32'h0000_FFFF, 32'h0000_FFFF, 3'd6, 0}, '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'd6, 2},
        '{32'h1234_5678, 32'h0000_0000, 3'd6, 0}, '{32'hDEAD_BEEF, 32'h1234_5678, 3'd7, 1}
    };

    int           lat;
    logic [W-1:0] ry;
    logic [4:0]   rf;
    bit           rs;
    bit           seen;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a_i = '0; b_i = '0; f_i = '0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_y", 64'(y), 64'd0);
        chk("rst_flags", 64'({zero, carry, ovf, neg, err}), 64'd0);

        // Request presented on a reset edge must be dropped.
        in_valid = 1'b1; a_i = 32'd1; b_i = 32'd1; f_i = 3'd4;
        @(negedge clk);
        chk("rst_req_out_valid", 64'(out_valid), 64'd0);
        chk("rst_req_in_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);

        do_op(32'hFFFF_FFFF, 32'h1, 3'd4, 0, 1'b0, lat, ry, rf, rs);
        chk("add_wrap_lat", 64'(lat), 64'd1);
        chk("add_wrap_y", 64'(ry), 64'd0);
        chk("add_wrap_flags", 64'(rf), 64'b11000);

        do_op(32'h8000_0000, 32'h1, 3'd5, 0, 1'b0, lat, ry, rf, rs);
        chk("sub_ovf_y", 64'(ry), 64'h7FFF_FFFF);
        chk("sub_ovf_flags", 64'(rf), 64'b00100);

        do_op(32'd3, 32'd5, 3'd5, 0, 1'b0, lat, ry, rf, rs);
        chk("sub_borrow_y", 64'(ry), 64'hFFFF_FFFE);
        chk("sub_borrow_flags", 64'(rf), 64'b01010);

        do_op(32'h0001_0000, 32'h0001_0003, 3'd6, 0, 1'b0, lat, ry, rf, rs);
`ifdef ALU_MULTICYCLE_MUL_EN
        chk("mul_lat", 64'(lat), 64'd33);
        chk("mul_y", 64'(ry), 64'h0003_0000);
        chk("mul_flags", 64'(rf), 64'b01000);
        chk("mul_in_ready_low", 64'(rs), 64'd0);
`else
        chk("op6_lat", 64'(lat), 64'd1);
        chk("op6_y", 64'(ry), 64'd0);
        chk("op6_flags", 64'(rf), 64'b10001);
`endif

        do_op(32'd0, 32'd0, 3'd3, 5, 1'b1, lat, ry, rf, rs);
        chk("nor_y", 64'(ry), 64'hFFFF_FFFF);
        chk("nor_flags", 64'(rf), 64'b00010);
        chk("nor_post_out_valid", 64'(out_valid), 64'd0);
        chk("nor_post_in_ready", 64'(in_ready), 64'd1);

        do_op(32'h1234_5678, 32'h9ABC_DEF0, 3'd7, 0, 1'b0, lat, ry, rf, rs);
        chk("op7_lat", 64'(lat), 64'd1);
        chk("op7_y", 64'(ry), 64'd0);
        chk("op7_flags", 64'(rf), 64'b10001);

`ifdef ALU_MULTICYCLE_MUL_EN
        // Reset in the middle of a multiply: its result must never appear.
        @(negedge clk);
        a_i = 32'd1234; b_i = 32'd5678; f_i = 3'd6; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        seen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            seen = seen | out_valid;
            @(negedge clk);
        end
        chk("mul_rst_no_valid", 64'(seen), 64'd0);
`endif
        do_op(32'd2, 32'd3, 3'd4, 0, 1'b0, lat, ry, rf, rs);
        chk("add_small_y", 64'(ry), 64'd5);
        chk("add_small_flags", 64'(rf), 64'd0);

        foreach (vecs[i]) begin
            do_op(vecs[i].x, vecs[i].z, vecs[i].op, vecs[i].hold, 1'b0, lat, ry, rf, rs);
            chk("vec_lat", 64'(lat), 64'(model_lat(vecs[i].op)));
        end

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time got 500000 want less");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter: WIDTH, default 32, operand/result width; legal range 4..64.
REQ-002 Port: clk  input  1  rising-edge clock; sole clock domain.
REQ-003 Port: rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-004 Port: in_valid  input  1  operation request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: a  input  WIDTH  operand A.
REQ-007 Port: b  input  WIDTH  operand B.
REQ-008 Port: f  input  3  opcode: 0 AND, 1 OR, 2 NAND, 3 NOR, 4 ADD, 5 SUB, 6 MUL, 7 illegal.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts result.
REQ-011 Port: y  output  WIDTH  result.
REQ-012 Port: zero, carry, ovf, neg, err  output  1 each  result flags.

Function
REQ-013 FSM states SHALL be IDLE, BUSY, DONE; in_ready SHALL equal (state==IDLE).
REQ-014 Accept SHALL occur on a rising edge with in_valid && in_ready; a, b, f SHALL be registered then and later input changes ignored.
REQ-015 Opcodes 0-5 and 7 SHALL go IDLE->DONE on the accept edge; out_valid high on the next cycle (1-cycle latency).
REQ-016 MUL SHALL go IDLE->BUSY, run an iterative shift-add over exactly WIDTH cycles, then BUSY->DONE; out_valid first high WIDTH+1 cycles after accept.
REQ-017 DONE SHALL hold y and all flags stable while out_ready is low; out_valid && out_ready SHALL move DONE->IDLE, out_valid low next cycle.
REQ-018 No new request SHALL be accepted in BUSY or DONE; in_ready rises the cycle after the result handshake.
REQ-019 ADD/SUB SHALL be modulo 2^WIDTH; MUL y SHALL be the low WIDTH bits of the 2*WIDTH-bit unsigned product.
REQ-020 carry: ADD = carry-out; SUB = borrow (1 iff a < b unsigned); MUL = 1 iff upper WIDTH product bits nonzero; logic ops = 0.
REQ-021 ovf: ADD/SUB = two's-complement signed overflow; all other opcodes = 0.
REQ-022 zero SHALL be (y==0); neg SHALL be y[WIDTH-1]; both valid for every opcode.
REQ-023 Opcode 7 SHALL produce y=0, err=1, carry=0, ovf=0, zero=1, neg=0; err=0 for all legal opcodes.
REQ-024 y and flags SHALL be 0 whenever out_valid is low.

Reset
REQ-025 rst_n low at a rising edge SHALL force IDLE, in_ready=1, out_valid=0, y=0, all flags 0, clear the MUL counter/accumulator, regardless of state.
REQ-026 Reset during BUSY or DONE SHALL discard the pending operation with no result ever presented.
REQ-027 A request presented during the reset edge SHALL NOT be accepted.

Configuration
REQ-028 Macro ALU_MULTICYCLE_MUL_EN defined: MUL implemented per REQ-016/019/020, BUSY state present.
REQ-029 Macro undefined: multiplier and BUSY state SHALL be omitted; opcode 6 SHALL behave exactly as opcode 7 (1-cycle, err=1, y=0).

Verification (WIDTH=32, macro defined unless stated)
REQ-030 ADD a=0xFFFFFFFF b=0x1, out_ready=1 -> out_valid next cycle, y=0, zero=1, carry=1, ovf=0, neg=0.
REQ-031 SUB a=0x80000000 b=0x1 -> y=0x7FFFFFFF, ovf=1, carry=0, neg=0; SUB a=3 b=5 -> y=0xFFFFFFFE, carry=1, neg=1.
REQ-032 MUL a=0x00010000 b=0x00010003 -> out_valid exactly 33 cycles after accept, y=0x00030000, carry=1; in_ready low throughout.
REQ-033 NOR a=0 b=0 with out_ready low 5 cycles -> y=0xFFFFFFFF, neg=1 held stable, in_ready low, second in_valid ignored until handshake.
REQ-034 rst_n low 10 cycles into MUL -> out_valid never rises for it; after release ADD 2+3 -> y=5, flags 0.
REQ-035 f=7, and f=6 with macro undefined -> y=0, err=1, zero=1, 1-cycle latency.
